// File: rtl/mcu_pkg.sv
// Shared MCU definitions: instruction-memory geometry and loader FSM states.
package mcu_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int INST_W_DEF = 17;

  typedef enum logic [3:0] {
    IDLE, HDR, B2, B1, B0, WRITE, CHK, DONE, ERR
  } ld_state_t;
endpackage

// File: rtl/imem_loader.sv
// Boot loader: assembles 3-byte instructions from a byte stream, writes them to
// sequential IMEM addresses, checks an XOR checksum and gates CPU reset.
module imem_loader
  import mcu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_wr_addr,
  output logic [INST_W-1:0] im_wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  ld_state_t         state_q, state_d;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] asm_q;
  logic [7:0]        acc_q;
  logic              xfer;

  assign xfer = byte_valid && byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    im_wr_en   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state_q)
      IDLE:  if (start) state_d = HDR;
      HDR:   begin byte_ready = 1'b1; if (byte_valid) state_d = B2; end
      B2:    begin byte_ready = 1'b1; if (byte_valid) state_d = B1; end
      B1:    begin byte_ready = 1'b1; if (byte_valid) state_d = B0; end
      B0:    begin byte_ready = 1'b1; if (byte_valid) state_d = WRITE; end
      // cnt counts down from H; H==0 wraps through 255..1, giving 256 writes
      WRITE: begin
        im_wr_en = 1'b1;
        state_d  = (cnt_q == 8'd1) ? CHK : B2;
      end
      CHK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = (byte_data == acc_q) ? DONE : ERR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = HDR;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_d = HDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= '0;
      asm_q  <= '0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: if (start) begin
          addr_q <= '0;
          acc_q  <= '0;
        end
        HDR: if (xfer) begin
          cnt_q <= byte_data;
          acc_q <= acc_q ^ byte_data;
        end
        B2: if (xfer) begin
          asm_q[INST_W-1] <= byte_data[0];
          acc_q           <= acc_q ^ byte_data;
        end
        B1: if (xfer) begin
          asm_q[15:8] <= byte_data;
          acc_q       <= acc_q ^ byte_data;
        end
        B0: if (xfer) begin
          asm_q[7:0] <= byte_data;
          acc_q      <= acc_q ^ byte_data;
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign im_wr_addr = addr_q;
  assign im_wr_data = asm_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues expected IMEM writes,
// a negedge monitor pops and compares them whenever im_wr_en is seen.
module tb_imem_loader;
  import mcu_pkg::*;

  typedef struct packed {
    logic [7:0]  a;
    logic [16:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, im_wr_en, cpu_hold, done, err;
  logic [7:0]  im_wr_addr;
  logic [16:0] im_wr_data;

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  c0 = 0;
  wr_t sb[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (im_wr_en === 1'b1) begin
      wr_t e;
      chk("ready_low_on_write", {31'd0, byte_ready}, 32'd0);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", im_wr_addr, im_wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {24'd0, im_wr_addr}, {24'd0, e.a});
        chk("wr_data", {15'd0, im_wr_data}, {15'd0, e.d});
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive a stream from a negedge; gaps inserts random byte_valid low cycles.
  task automatic send(input logic [7:0] s[$], input bit gaps);
    int idx = 0;
    int budget = 20000;
    logic v;
    while (idx < s.size() && budget > 0) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_valid = v;
      byte_data  = s[idx];
      if (v && byte_ready) idx++;
      @(negedge clk);
      budget--;
    end
    byte_valid = 1'b0;
    if (budget == 0) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_end();
    int budget = 5000;
    while (!(done || err) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("end_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_good();
    sb.push_back('{a: 8'h00, d: 17'h1ABCD});
    sb.push_back('{a: 8'h01, d: 17'h00012});
  endtask

  logic [7:0] good[$] = '{8'h02, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h12, 8'h77};
  logic [7:0] bad[$]  = '{8'h02, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h12, 8'h76};
  logic [7:0] part[$] = '{8'h02, 8'h01, 8'hAB};
  logic [7:0] full[$];

  initial begin
    logic [7:0] ck, b2, b1, b0;

    // Reset asserted mid-cycle
    #3 rst = 1'b1;
    @(negedge clk);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_wr_en",      {31'd0, im_wr_en},   32'd0);
    chk("rst_wr_addr",    {24'd0, im_wr_addr}, 32'd0);
    chk("rst_wr_data",    {15'd0, im_wr_data}, 32'd0);
    chk("rst_status",     {29'd0, cpu_hold, done, err}, 32'b100);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", {31'd0, byte_ready}, 32'd0);

    // Good load, valid held high: 11 cycles start -> done
    push_good();
    pulse_start();
    chk("hdr_ready", {31'd0, byte_ready}, 32'd1);
    send(good, 1'b0);
    wait_end();
    chk("good_latency", cyc - c0, 32'd11);
    chk("good_status", {29'd0, cpu_hold, done, err}, 32'b010);
    chk("good_sb_empty", sb.size(), 32'd0);

    // Bad checksum, then a clean reload
    push_good();
    pulse_start();
    chk("restart_clears", {29'd0, cpu_hold, done, err}, 32'b100);
    send(bad, 1'b0);
    wait_end();
    chk("bad_status", {29'd0, cpu_hold, done, err}, 32'b101);
    chk("bad_sb_empty", sb.size(), 32'd0);
    push_good();
    pulse_start();
    send(good, 1'b0);
    wait_end();
    chk("reload_status", {29'd0, cpu_hold, done, err}, 32'b010);

    // Full-depth load: H=0 means 256 instructions
    full.delete();
    full.push_back(8'h00);
    ck = 8'h00;
    for (int i = 0; i < 256; i++) begin
      b2 = i[7:0] ^ 8'hC3;
      b1 = i[7:0] ^ 8'h5A;
      b0 = ~i[7:0];
      full.push_back(b2); full.push_back(b1); full.push_back(b0);
      ck = ck ^ b2 ^ b1 ^ b0;
      sb.push_back('{a: i[7:0], d: {b2[0], b1, b0}});
    end
    full.push_back(ck);
    pulse_start();
    send(full, 1'b0);
    wait_end();
    chk("full_status", {29'd0, cpu_hold, done, err}, 32'b010);
    chk("full_sb_empty", sb.size(), 32'd0);
    chk("full_addr_wrap", {24'd0, im_wr_addr}, 32'd0);

    // Backpressure: random gaps, same data
    push_good();
    pulse_start();
    send(good, 1'b1);
    wait_end();
    chk("bp_status", {29'd0, cpu_hold, done, err}, 32'b010);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Reset after the 4th accepted byte, before its write strobe
    pulse_start();
    send(part, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'hCD;
    @(posedge clk);
    #1 rst = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrst_status", {29'd0, cpu_hold, done, err}, 32'b100);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_idle", {31'd0, byte_ready}, 32'd0);
    chk("midrst_no_write", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
